// File: rtl/fp_addsub_arbiter.sv
// Round-robin front end sharing one add_sub_main unit between N_REQ requesters.
// Tags follow each issued operation through the unit; results return in order via a credited FIFO.
module fp_addsub_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_op,
  output logic [WIDTH-1:0]       unit_a,
  output logic [WIDTH-1:0]       unit_b,
  output logic                   unit_op,
  input  logic [WIDTH-1:0]       unit_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // The tag is captured alongside the operand register, so it needs one extra stage
  // to line up with unit_result becoming valid LATENCY edges later.
  localparam int unsigned TagStages = LATENCY + 1;

  logic                  run_q;
  logic [ID_W-1:0]       ptr_q, ptr_d, gnt_idx;
  logic                  gnt_found, can_grant, accept, pop, push;
  logic [CntW-1:0]       outstanding_q, outstanding_d;
  logic [WIDTH-1:0]      unit_a_q, unit_b_q, sel_a, sel_b;
  logic                  unit_op_q, sel_op, busy_q;
  logic                  tag_vld_q [TagStages];
  logic [ID_W-1:0]       tag_id_q  [TagStages];
  logic [WIDTH-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [ID_W-1:0]       fifo_id_q   [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Search from ptr upward first, then wrap to the lowest index below ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
  end

  assign can_grant = run_q && (outstanding_q < CntW'(FIFO_DEPTH)) && gnt_found;

  always_comb begin
    req_ready = '0;
    if (can_grant) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);
  assign pop    = rsp_valid & rsp_ready;
  assign push   = tag_vld_q[TagStages-1];

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !pop) begin
      outstanding_d = outstanding_q + CntW'(1);
    end else if (!accept && pop) begin
      outstanding_d = outstanding_q - CntW'(1);
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CntW'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q         <= 1'b0;
      ptr_q         <= '0;
      outstanding_q <= '0;
      busy_q        <= 1'b0;
      unit_a_q      <= '0;
      unit_b_q      <= '0;
      unit_op_q     <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
      busy_q        <= (outstanding_d != '0);
      if (accept) begin
        unit_a_q  <= sel_a;
        unit_b_q  <= sel_b;
        unit_op_q <= sel_op;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TagStages; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= accept;
      tag_id_q[0]  <= gnt_idx;
      for (int i = 1; i < TagStages; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= unit_result;
        fifo_id_q[wr_ptr_q]   <= tag_id_q[TagStages-1];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  assign unit_a    = unit_a_q;
  assign unit_b    = unit_b_q;
  assign unit_op   = unit_op_q;
  assign rsp_valid = (fifo_cnt_q != '0);
  assign rsp_id    = fifo_id_q[rd_ptr_q];
  assign rsp_data  = fifo_data_q[rd_ptr_q];
  assign busy      = busy_q;

  // Credits bound the FIFO; a push into a full FIFO without a pop means the credit logic broke.
  fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (fifo_cnt_q == CntW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Randomized bench for fp_addsub_arbiter with a registered behavioural FP unit and a
// queue-based reference predicting grants, unit operands and in-order responses.
module tb_fp_addsub_arbiter;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned N_REQ      = 4;
  localparam int unsigned LATENCY    = 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ID_W       = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid, req_ready, req_op;
  logic [N_REQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]       unit_a, unit_b, unit_result;
  logic                   unit_op, rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;

  always #5 clk = ~clk;

  fp_addsub_arbiter #(
    .WIDTH      (WIDTH),
    .N_REQ      (N_REQ),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ID_W       (ID_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_op     (unit_op),
    .unit_result (unit_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  // Single-precision <-> real helpers, exact for the normal values used here.
  function automatic real sp2real(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'({3'b000, b[30:23]} + 11'd896), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] int2sp(input int v);
    logic [31:0] mag, m;
    int msb;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    msb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
    m = mag << (23 - msb);
    return {v < 0, 8'(127 + msb), m[22:0]};
  endfunction

  // Stand-in for add_sub_main with LATENCY = 1.
  always @(posedge clk)
    unit_result <= real2sp(unit_op ? sp2real(unit_a) - sp2real(unit_b)
                                   : sp2real(unit_a) + sp2real(unit_b));

  typedef struct {
    int          id;
    logic [31:0] data;
    int          vis;
  } exp_t;

  exp_t        q[$];
  int          m_ptr, cyc, n_cmp, n_err, dut_acc, acc0;
  bit          m_run;
  logic [31:0] m_ua, m_ub;
  logic        m_uop;
  int          pend_a[N_REQ], pend_b[N_REQ], rep[N_REQ];
  bit          pend_op[N_REQ], acc_now[N_REQ];
  bit          auto_mode;
  int          p_valid, p_rready, p_drop;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = int2sp(pend_a[i]);
      req_b[i*WIDTH +: WIDTH] = int2sp(pend_b[i]);
      req_op[i]               = pend_op[i];
    end
  endtask

  function automatic int rnd_val();
    return int'($urandom_range(0, 2097152)) - 1048576;
  endfunction

  task automatic new_op(input int i);
    pend_a[i]    = rnd_val();
    pend_b[i]    = rnd_val();
    pend_op[i]   = $urandom_range(0, 1) == 1;
    req_valid[i] = 1'b1;
  endtask

  task automatic set_req(input int i, input int a, input int b, input bit op, input int r);
    pend_a[i]    = a;
    pend_b[i]    = b;
    pend_op[i]   = op;
    rep[i]       = r;
    req_valid[i] = 1'b1;
    drive_bus();
  endtask

  task automatic step();
    logic [N_REQ-1:0] exp_ready;
    bit               found, exp_rv;
    int               g;
    exp_t             e;
    @(negedge clk);
    exp_ready = '0;
    found     = 1'b0;
    g         = 0;
    if (m_run && q.size() < FIFO_DEPTH) begin
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % N_REQ;
        if (!found && req_valid[idx]) begin
          found          = 1'b1;
          g              = idx;
          exp_ready[idx] = 1'b1;
        end
      end
    end
    exp_rv = 1'b0;
    if (q.size() > 0) exp_rv = (q[0].vis <= cyc);
    check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
    check_eq("busy", 64'(busy), 64'(q.size() != 0));
    check_eq("unit_a", 64'(unit_a), 64'(m_ua));
    check_eq("unit_b", 64'(unit_b), 64'(m_ub));
    check_eq("unit_op", 64'(unit_op), 64'(m_uop));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv && rsp_valid) begin
      check_eq("rsp_id", 64'(rsp_id), 64'(q[0].id));
      check_eq("rsp_data", 64'(rsp_data), 64'(q[0].data));
    end
    dut_acc += $countones(req_valid & req_ready);
    for (int i = 0; i < N_REQ; i++) acc_now[i] = 1'b0;
    if (exp_rv && rsp_ready) void'(q.pop_front());
    if (found) begin
      e.id   = g;
      e.data = int2sp(pend_op[g] ? pend_a[g] - pend_b[g] : pend_a[g] + pend_b[g]);
      e.vis  = cyc + LATENCY + 2;
      q.push_back(e);
      m_ua       = int2sp(pend_a[g]);
      m_ub       = int2sp(pend_b[g]);
      m_uop      = pend_op[g];
      m_ptr      = (g + 1) % N_REQ;
      acc_now[g] = 1'b1;
    end
    @(posedge clk);
    m_run = (reset === 1'b1);
    cyc++;
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc_now[i]) begin
        if (auto_mode) begin
          if ($urandom_range(0, 99) < p_valid) new_op(i);
          else req_valid[i] = 1'b0;
        end else if (rep[i] > 0) begin
          rep[i]--;
        end else begin
          req_valid[i] = 1'b0;
        end
      end else if (auto_mode) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 99) < p_valid) new_op(i);
        end else if ($urandom_range(0, 99) < p_drop) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    rsp_ready = $urandom_range(0, 99) < p_rready;
    drive_bus();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q.delete();
    m_ptr = 0;
    m_run = 1'b0;
    m_ua  = '0;
    m_ub  = '0;
    m_uop = 1'b0;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'(0));
    check_eq("rst_unit_a", 64'(unit_a), 64'(0));
    check_eq("rst_unit_b", 64'(unit_b), 64'(0));
    check_eq("rst_unit_op", 64'(unit_op), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_rsp_id", 64'(rsp_id), 64'(0));
    check_eq("rst_rsp_data", 64'(rsp_data), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
  endtask

  task automatic drain();
    auto_mode = 1'b0;
    req_valid = '0;
    p_rready  = 100;
    rsp_ready = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    auto_mode = 1'b0;
    p_valid   = 0;
    p_rready  = 100;
    p_drop    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      pend_a[i]  = 0;
      pend_b[i]  = 0;
      pend_op[i] = 1'b0;
      rep[i]     = 0;
    end
    drive_bus();
    #2;
    do_reset();

    // Requester 0 already valid at release: no grant on the first edge.
    set_req(0, 5, 7, 1'b0, 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (6) step();

    // Single add 1.0 + 2.0 from requester 2.
    set_req(2, 1, 2, 1'b0, 0);
    check_eq("single_add_operand", 64'(req_a[2*WIDTH +: WIDTH]), 64'(32'h3F80_0000));
    repeat (6) step();

    // All requesters continuously valid.
    auto_mode = 1'b1;
    p_valid   = 100;
    p_rready  = 100;
    p_drop    = 0;
    for (int i = 0; i < N_REQ; i++) new_op(i);
    drive_bus();
    repeat (40) step();
    drain();

    // Subtract 3.0 - 1.0 six times against a stalled consumer.
    p_rready  = 0;
    rsp_ready = 1'b0;
    acc0      = dut_acc;
    set_req(1, 3, 1, 1'b1, 5);
    repeat (10) step();
    check_eq("bp_accepts", 64'(dut_acc - acc0), 64'(4));
    check_eq("bp_ready_held", 64'(req_ready), 64'(0));
    p_rready  = 100;
    rsp_ready = 1'b1;
    repeat (14) step();
    check_eq("bp_total_accepts", 64'(dut_acc - acc0), 64'(6));
    drain();

    // Three results queued, one in flight, pop lands on the same edge as the push.
    p_rready  = 0;
    rsp_ready = 1'b0;
    set_req(3, 10, -4, 1'b0, 3);
    repeat (5) step();
    check_eq("full_rsp_valid", 64'(rsp_valid), 64'(1));
    p_rready  = 100;
    rsp_ready = 1'b1;
    repeat (8) step();
    drain();

    // Random soak.
    auto_mode = 1'b1;
    p_valid   = 60;
    p_rready  = 50;
    p_drop    = 10;
    repeat (300) step();
    drain();

    // Reset one cycle after an accept.
    set_req(2, 100, 50, 1'b1, 0);
    repeat (2) step();
    do_reset();
    repeat (3) step();
    for (int i = 0; i < N_REQ; i++) set_req(i, i, i + 1, 1'b0, 0);
    reset = 1'b1;
    repeat (8) step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
